// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the alu slice.
//   - mode select constants (MODE input)
//   - command codes for the arithmetic and logical command sets
//   - IN_VALID encodings (bit0 = OPA valid, bit1 = OPB valid)
package alu_pkg;

   localparam logic MODE_LOGIC = 1'b0;
   localparam logic MODE_ARITH = 1'b1;

   // Arithmetic command set (MODE = 1)
   localparam logic [3:0] A_ADD     = 4'd0;
   localparam logic [3:0] A_SUB     = 4'd1;
   localparam logic [3:0] A_ADD_CIN = 4'd2;
   localparam logic [3:0] A_SUB_CIN = 4'd3;
   localparam logic [3:0] A_INC_A   = 4'd4;
   localparam logic [3:0] A_DEC_A   = 4'd5;
   localparam logic [3:0] A_INC_B   = 4'd6;
   localparam logic [3:0] A_DEC_B   = 4'd7;
   localparam logic [3:0] A_CMP     = 4'd8;
   localparam logic [3:0] A_MUL_INC = 4'd9;
   localparam logic [3:0] A_MUL_SHL = 4'd10;

   // Logical command set (MODE = 0)
   localparam logic [3:0] L_AND    = 4'd0;
   localparam logic [3:0] L_NAND   = 4'd1;
   localparam logic [3:0] L_OR     = 4'd2;
   localparam logic [3:0] L_NOR    = 4'd3;
   localparam logic [3:0] L_XOR    = 4'd4;
   localparam logic [3:0] L_XNOR   = 4'd5;
   localparam logic [3:0] L_NOT_A  = 4'd6;
   localparam logic [3:0] L_NOT_B  = 4'd7;
   localparam logic [3:0] L_SHR1_A = 4'd8;
   localparam logic [3:0] L_SHL1_A = 4'd9;
   localparam logic [3:0] L_SHR1_B = 4'd10;
   localparam logic [3:0] L_SHL1_B = 4'd11;
   localparam logic [3:0] L_ROL    = 4'd12;
   localparam logic [3:0] L_ROR    = 4'd13;

   // Operand-valid encodings
   localparam logic [1:0] IV_NONE = 2'b00;
   localparam logic [1:0] IV_A    = 2'b01;
   localparam logic [1:0] IV_B    = 2'b10;
   localparam logic [1:0] IV_AB   = 2'b11;

endpackage

// File: rtl/alu_multiplier.sv
// alu_multiplier: two-stage registered multiplier.
//   Stage 1 captures the operands when start_i is high; stage 2 captures
//   the product, but only when finish_i confirms the operation was not
//   superseded, so a cancelled multiply never disturbs prod_o.
// Ports:
//   clk_i, srst_i   clock, synchronous active-high reset
//   ce_i            clock enable; 0 freezes both stages
//   start_i         launch a multiply with a_i/b_i
//   finish_i        complete the multiply held in stage 1
//   a_i, b_i        operands (OP_W bits)
//   busy_o          stage 1 holds a launched multiply
//   prod_o          product, truncated to OUT_W bits
module alu_multiplier #(
   parameter int OP_W  = 9,
   parameter int OUT_W = 16
) (
   input  logic             clk_i,
   input  logic             srst_i,
   input  logic             ce_i,
   input  logic             start_i,
   input  logic             finish_i,
   input  logic [OP_W-1:0]  a_i,
   input  logic [OP_W-1:0]  b_i,
   output logic             busy_o,
   output logic [OUT_W-1:0] prod_o
);

   logic [OP_W-1:0]  a_q, b_q;
   logic             busy_q;
   logic [OUT_W-1:0] prod_q;
   logic [OUT_W-1:0] a_ext, b_ext;

   // Operands widened to the output width; the product is kept modulo 2^OUT_W.
   assign a_ext = {{(OUT_W-OP_W){1'b0}}, a_q};
   assign b_ext = {{(OUT_W-OP_W){1'b0}}, b_q};

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         a_q    <= '0;
         b_q    <= '0;
         busy_q <= 1'b0;
         prod_q <= '0;
      end else if (ce_i) begin
         busy_q <= start_i;
         if (start_i) begin
            a_q <= a_i;
            b_q <= b_i;
         end
         if (busy_q && finish_i) begin
            prod_q <= a_ext * b_ext;
         end
      end
   end

   assign busy_o = busy_q;
   assign prod_o = prod_q;

endmodule

// File: rtl/alu.sv
// alu: registered arithmetic/logic unit.
//   One combinational decode/compute block feeds an output register stage.
//   Single-cycle ops update the outputs at the sampling edge; MUL_INC and
//   MUL_SHL go through alu_multiplier and appear one enabled edge later.
//   While a multiply is in flight, an enabled edge presenting the same
//   command and operands is the front end holding that multiply (it then
//   completes); any other command is new and cancels it.
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   CE             clock enable; 0 freezes outputs and in-flight state
//   MODE           1 = arithmetic command set, 0 = logical command set
//   CMD            operation select
//   IN_VALID       bit0 = OPA valid, bit1 = OPB valid
//   OPA, OPB, CIN  operands and carry/borrow input
//   RES            2*WIDTH result; COUT/OFLOW carry and overflow flags
//   E, G, L        compare flags; ERR illegal command / operand error
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int CMD_WIDTH = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 CE,
   input  logic                 MODE,
   input  logic [CMD_WIDTH-1:0] CMD,
   input  logic [1:0]           IN_VALID,
   input  logic [WIDTH-1:0]     OPA,
   input  logic [WIDTH-1:0]     OPB,
   input  logic                 CIN,
   output logic [2*WIDTH-1:0]   RES,
   output logic                 COUT,
   output logic                 OFLOW,
   output logic                 E,
   output logic                 G,
   output logic                 L,
   output logic                 ERR
);

   localparam int SHW   = $clog2(WIDTH);
   localparam int KEY_W = 1 + CMD_WIDTH + 2 + 2*WIDTH;
   localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
   localparam logic [WIDTH:0] CIN_PAD = '0;

   logic [2*WIDTH-1:0] res_d, res_q;
   logic               cout_d, cout_q, oflow_d, oflow_q;
   logic               e_d, e_q, g_d, g_q, l_d, l_q, err_d, err_q;
   logic               sel_q;
   logic [KEY_W-1:0]   key_d, key_q;
   logic               mul_d;
   logic [WIDTH:0]     mul_a_d, mul_b_d;
   logic [WIDTH:0]     ext;
   logic [WIDTH-1:0]   lres;
   logic [2*WIDTH-1:0] dbl, rot;
   logic               defined, need_a, need_b, is_rot, rot_bad, ok;
   logic               mul_busy, hold, start;
   logic [2*WIDTH-1:0] mul_prod;

   always_comb begin
      res_d   = '0;
      cout_d  = 1'b0;
      oflow_d = 1'b0;
      e_d     = 1'b0;
      g_d     = 1'b0;
      l_d     = 1'b0;
      err_d   = 1'b0;
      mul_d   = 1'b0;
      mul_a_d = '0;
      mul_b_d = '0;
      ext     = '0;
      lres    = '0;
      rot     = '0;
      defined = 1'b1;
      need_a  = 1'b1;
      need_b  = 1'b1;
      is_rot  = 1'b0;
      dbl     = {OPA, OPA};
      rot_bad = (OPB >> SHW) != '0;

      if (MODE == MODE_ARITH) begin
         case (CMD)
            A_ADD:     ext = {1'b0, OPA} + {1'b0, OPB};
            A_SUB:     ext = {1'b0, OPA} - {1'b0, OPB};
            A_ADD_CIN: ext = {1'b0, OPA} + {1'b0, OPB} + (CIN_PAD | (WIDTH+1)'(CIN));
            A_SUB_CIN: ext = {1'b0, OPA} - {1'b0, OPB} - (CIN_PAD | (WIDTH+1)'(CIN));
            A_INC_A:   begin need_b = 1'b0; ext = {1'b0, OPA} + ONE; end
            A_DEC_A:   begin need_b = 1'b0; ext = {1'b0, OPA} - ONE; end
            A_INC_B:   begin need_a = 1'b0; ext = {1'b0, OPB} + ONE; end
            A_DEC_B:   begin need_a = 1'b0; ext = {1'b0, OPB} - ONE; end
            A_CMP: begin
               e_d = (OPA == OPB);
               g_d = (OPA > OPB);
               l_d = (OPA < OPB);
            end
            A_MUL_INC: begin
               mul_d   = 1'b1;
               mul_a_d = {1'b0, OPA} + ONE;
               mul_b_d = {1'b0, OPB} + ONE;
            end
            A_MUL_SHL: begin
               mul_d   = 1'b1;
               mul_a_d = {1'b0, OPA[WIDTH-2:0], 1'b0};
               mul_b_d = {1'b0, OPB};
            end
            default:   defined = 1'b0;
         endcase
         // Bit WIDTH of the extended result is the carry or the borrow.
         res_d   = {{(WIDTH-1){1'b0}}, ext};
         cout_d  = ext[WIDTH];
         oflow_d = ext[WIDTH];
      end else begin
         case (CMD)
            L_AND:    lres = OPA & OPB;
            L_NAND:   lres = ~(OPA & OPB);
            L_OR:     lres = OPA | OPB;
            L_NOR:    lres = ~(OPA | OPB);
            L_XOR:    lres = OPA ^ OPB;
            L_XNOR:   lres = ~(OPA ^ OPB);
            L_NOT_A:  begin need_b = 1'b0; lres = ~OPA; end
            L_NOT_B:  begin need_a = 1'b0; lres = ~OPB; end
            L_SHR1_A: begin need_b = 1'b0; lres = {1'b0, OPA[WIDTH-1:1]}; end
            L_SHL1_A: begin need_b = 1'b0; lres = {OPA[WIDTH-2:0], 1'b0}; end
            L_SHR1_B: begin need_a = 1'b0; lres = {1'b0, OPB[WIDTH-1:1]}; end
            L_SHL1_B: begin need_a = 1'b0; lres = {OPB[WIDTH-2:0], 1'b0}; end
            // Rotates shift a doubled copy of A so wrapped bits fall into place.
            L_ROL: begin
               is_rot = 1'b1;
               rot    = dbl << OPB[SHW-1:0];
               lres   = rot[2*WIDTH-1:WIDTH];
            end
            L_ROR: begin
               is_rot = 1'b1;
               rot    = dbl >> OPB[SHW-1:0];
               lres   = rot[WIDTH-1:0];
            end
            default:  defined = 1'b0;
         endcase
         res_d = {{WIDTH{1'b0}}, lres};
      end

      // Every command needs at least one operand, so IN_VALID=00 always fails.
      ok = defined && (!need_a || IN_VALID[0]) && (!need_b || IN_VALID[1])
           && !(is_rot && rot_bad);
      if (!ok) begin
         res_d   = '0;
         cout_d  = 1'b0;
         oflow_d = 1'b0;
         e_d     = 1'b0;
         g_d     = 1'b0;
         l_d     = 1'b0;
         mul_d   = 1'b0;
         err_d   = 1'b1;
      end
   end

   assign key_d = {MODE, CMD, IN_VALID, OPA, OPB};
   assign hold  = mul_busy && (key_d == key_q);
   assign start = mul_d && !hold;

   alu_multiplier #(
      .OP_W  (WIDTH + 1),
      .OUT_W (2*WIDTH)
   ) u_mul (
      .clk_i    (CLK),
      .srst_i   (RST),
      .ce_i     (CE),
      .start_i  (start),
      .finish_i (hold),
      .a_i      (mul_a_d),
      .b_i      (mul_b_d),
      .busy_o   (mul_busy),
      .prod_o   (mul_prod)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         res_q   <= '0;
         cout_q  <= 1'b0;
         oflow_q <= 1'b0;
         e_q     <= 1'b0;
         g_q     <= 1'b0;
         l_q     <= 1'b0;
         err_q   <= 1'b0;
         sel_q   <= 1'b0;
         key_q   <= '0;
      end else if (CE) begin
         if (start) begin
            key_q <= key_d;
         end
         if (hold) begin
            // Multiply completes: RES switches to the product register.
            sel_q   <= 1'b1;
            cout_q  <= 1'b0;
            oflow_q <= 1'b0;
            e_q     <= 1'b0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            err_q   <= 1'b0;
         end else if (!start) begin
            sel_q   <= 1'b0;
            res_q   <= res_d;
            cout_q  <= cout_d;
            oflow_q <= oflow_d;
            e_q     <= e_d;
            g_q     <= g_d;
            l_q     <= l_d;
            err_q   <= err_d;
         end
         // A freshly launched multiply leaves the outputs untouched.
      end
   end

   assign RES   = sel_q ? mul_prod : res_q;
   assign COUT  = cout_q;
   assign OFLOW = oflow_q;
   assign E     = e_q;
   assign G     = g_q;
   assign L     = l_q;
   assign ERR   = err_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: table-driven bench for alu (WIDTH=8) plus hand-written
// sequences for reset, clock enable and the two-cycle multiplies.
module tb_alu;
   import alu_pkg::*;

   logic        CLK = 1'b0;
   logic        RST, CE, MODE, CIN;
   logic [3:0]  CMD;
   logic [1:0]  IN_VALID;
   logic [7:0]  OPA, OPB;
   logic [15:0] RES;
   logic        COUT, OFLOW, E, G, L, ERR;

   int checks   = 0;
   int failures = 0;

   logic [15:0] last_res;
   logic [5:0]  last_flg;

   always #5 CLK = ~CLK;

   alu #(.WIDTH(8), .CMD_WIDTH(4)) dut (
      .CLK(CLK), .RST(RST), .CE(CE), .MODE(MODE), .CMD(CMD),
      .IN_VALID(IN_VALID), .OPA(OPA), .OPB(OPB), .CIN(CIN),
      .RES(RES), .COUT(COUT), .OFLOW(OFLOW), .E(E), .G(G), .L(L), .ERR(ERR)
   );

   // flags are {COUT, OFLOW, E, G, L, ERR}
   typedef struct {
      logic        mode;
      logic [3:0]  cmd;
      logic [1:0]  iv;
      logic [7:0]  a;
      logic [7:0]  b;
      logic        cin;
      logic [15:0] res;
      logic [5:0]  flg;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic m, input logic [3:0] c, input logic [1:0] iv,
                               input logic [7:0] a, input logic [7:0] b, input logic ci,
                               input logic [15:0] r, input logic [5:0] f);
      vec_t v;
      v.mode = m; v.cmd = c; v.iv = iv; v.a = a; v.b = b; v.cin = ci;
      v.res = r; v.flg = f;
      return v;
   endfunction

   task automatic set_in(input logic m, input logic [3:0] c, input logic [1:0] iv,
                         input logic [7:0] a, input logic [7:0] b, input logic ci);
      MODE = m; CMD = c; IN_VALID = iv; OPA = a; OPB = b; CIN = ci;
   endtask

   task automatic check(input string name, input logic [15:0] eres, input logic [5:0] eflg);
      logic [5:0] got;
      got = {COUT, OFLOW, E, G, L, ERR};
      checks++;
      if (RES !== eres || got !== eflg) begin
         failures++;
         $display("FAIL %s: got RES=%h flags=%b, expected RES=%h flags=%b",
                  name, RES, got, eres, eflg);
      end else begin
         $display("ok   %s: RES=%h flags=%b", name, RES, got);
      end
      last_res = eres;
      last_flg = eflg;
   endtask

   task automatic edge_wait();
      @(posedge CLK);
      #1;
   endtask

   // Multiply with inputs held across both enabled edges.
   task automatic mul_seq(input string name, input logic [3:0] c,
                          input logic [7:0] a, input logic [7:0] b, input logic [15:0] prod);
      @(negedge CLK);
      set_in(MODE_ARITH, c, IV_AB, a, b, 1'b0);
      edge_wait();
      check({name, "_mid"}, last_res, last_flg);
      edge_wait();
      check(name, prod, 6'b000000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      last_res = '0;
      last_flg = '0;

      // Reset with live inputs and CE high
      RST = 1'b1; CE = 1'b1;
      set_in(MODE_ARITH, A_ADD, IV_AB, 8'hFF, 8'h01, 1'b0);
      edge_wait();
      check("reset", 16'h0000, 6'b000000);
      @(negedge CLK);
      RST = 1'b0; CE = 1'b0;
      edge_wait();
      check("ce0_hold1", 16'h0000, 6'b000000);
      edge_wait();
      check("ce0_hold2", 16'h0000, 6'b000000);

      // Directed vector table
      vecs.push_back(mk(MODE_ARITH, A_ADD,     IV_AB, 8'hFF, 8'h01, 1'b0, 16'h0100, 6'b110000));
      vecs.push_back(mk(MODE_ARITH, A_SUB,     IV_AB, 8'h05, 8'h0A, 1'b0, 16'h01FB, 6'b110000));
      vecs.push_back(mk(MODE_ARITH, A_ADD_CIN, IV_AB, 8'h10, 8'h20, 1'b1, 16'h0031, 6'b000000));
      vecs.push_back(mk(MODE_ARITH, A_ADD_CIN, IV_AB, 8'hFF, 8'h00, 1'b1, 16'h0100, 6'b110000));
      vecs.push_back(mk(MODE_ARITH, A_SUB_CIN, IV_AB, 8'h20, 8'h10, 1'b1, 16'h000F, 6'b000000));
      vecs.push_back(mk(MODE_ARITH, A_SUB_CIN, IV_AB, 8'h10, 8'h10, 1'b1, 16'h01FF, 6'b110000));
      vecs.push_back(mk(MODE_ARITH, A_INC_A,   IV_A,  8'hFF, 8'h55, 1'b0, 16'h0100, 6'b110000));
      vecs.push_back(mk(MODE_ARITH, A_DEC_A,   IV_A,  8'h00, 8'h55, 1'b0, 16'h01FF, 6'b110000));
      vecs.push_back(mk(MODE_ARITH, A_INC_B,   IV_B,  8'h99, 8'h07, 1'b0, 16'h0008, 6'b000000));
      vecs.push_back(mk(MODE_ARITH, A_DEC_B,   IV_B,  8'h99, 8'h07, 1'b0, 16'h0006, 6'b000000));
      vecs.push_back(mk(MODE_ARITH, A_CMP,     IV_AB, 8'h3C, 8'h3C, 1'b0, 16'h0000, 6'b001000));
      vecs.push_back(mk(MODE_ARITH, A_CMP,     IV_AB, 8'h10, 8'h20, 1'b0, 16'h0000, 6'b000010));
      vecs.push_back(mk(MODE_ARITH, A_CMP,     IV_AB, 8'h20, 8'h10, 1'b0, 16'h0000, 6'b000100));
      vecs.push_back(mk(MODE_LOGIC, L_ROL,     IV_AB, 8'h81, 8'h01, 1'b0, 16'h0003, 6'b000000));
      vecs.push_back(mk(MODE_LOGIC, L_ROL,     IV_AB, 8'h81, 8'h10, 1'b0, 16'h0000, 6'b000001));
      vecs.push_back(mk(MODE_LOGIC, L_NAND,    IV_AB, 8'hF0, 8'hFF, 1'b0, 16'h000F, 6'b000000));
      vecs.push_back(mk(MODE_LOGIC, L_AND,     IV_AB, 8'hC3, 8'h0F, 1'b0, 16'h0003, 6'b000000));
      vecs.push_back(mk(MODE_LOGIC, L_OR,      IV_AB, 8'hC3, 8'h0F, 1'b0, 16'h00CF, 6'b000000));
      vecs.push_back(mk(MODE_LOGIC, L_NOR,     IV_AB, 8'hC3, 8'h0F, 1'b0, 16'h0030, 6'b000000));
      vecs.push_back(mk(MODE_LOGIC, L_XOR,     IV_AB, 8'hC3, 8'h0F, 1'b0, 16'h00CC, 6'b000000));
      vecs.push_back(mk(MODE_LOGIC, L_XNOR,    IV_AB, 8'hC3, 8'h0F, 1'b0, 16'h0033, 6'b000000));
      vecs.push_back(mk(MODE_LOGIC, L_NOT_A,   IV_A,  8'hC3, 8'h0F, 1'b0, 16'h003C, 6'b000000));
      vecs.push_back(mk(MODE_LOGIC, L_NOT_B,   IV_B,  8'hC3, 8'h0F, 1'b0, 16'h00F0, 6'b000000));
      vecs.push_back(mk(MODE_LOGIC, L_SHR1_A,  IV_A,  8'h81, 8'h00, 1'b0, 16'h0040, 6'b000000));
      vecs.push_back(mk(MODE_LOGIC, L_SHL1_A,  IV_A,  8'h81, 8'h00, 1'b0, 16'h0002, 6'b000000));
      vecs.push_back(mk(MODE_LOGIC, L_SHR1_B,  IV_B,  8'h00, 8'h03, 1'b0, 16'h0001, 6'b000000));
      vecs.push_back(mk(MODE_LOGIC, L_SHL1_B,  IV_B,  8'h00, 8'hC0, 1'b0, 16'h0080, 6'b000000));
      vecs.push_back(mk(MODE_LOGIC, L_ROR,     IV_AB, 8'h81, 8'h01, 1'b0, 16'h00C0, 6'b000000));
      vecs.push_back(mk(MODE_LOGIC, L_ROL,     IV_AB, 8'h81, 8'h07, 1'b0, 16'h00C0, 6'b000000));
      vecs.push_back(mk(MODE_LOGIC, L_ROR,     IV_AB, 8'h01, 8'h08, 1'b0, 16'h0000, 6'b000001));
      vecs.push_back(mk(MODE_LOGIC, L_AND,     IV_AB, 8'hFF, 8'h5A, 1'b0, 16'h005A, 6'b000000));
      vecs.push_back(mk(MODE_ARITH, A_INC_A,   IV_B,  8'h01, 8'h01, 1'b0, 16'h0000, 6'b000001));
      vecs.push_back(mk(MODE_ARITH, A_ADD,     IV_AB, 8'h01, 8'h01, 1'b0, 16'h0002, 6'b000000));
      vecs.push_back(mk(MODE_LOGIC, 4'd15,     IV_AB, 8'h01, 8'h01, 1'b0, 16'h0000, 6'b000001));
      vecs.push_back(mk(MODE_ARITH, A_ADD,     IV_NONE, 8'h01, 8'h01, 1'b0, 16'h0000, 6'b000001));
      vecs.push_back(mk(MODE_ARITH, 4'd11,     IV_AB, 8'h01, 8'h01, 1'b0, 16'h0000, 6'b000001));
      vecs.push_back(mk(MODE_LOGIC, 4'd14,     IV_AB, 8'h01, 8'h01, 1'b0, 16'h0000, 6'b000001));
      vecs.push_back(mk(MODE_ARITH, A_SUB,     IV_A,  8'h01, 8'h01, 1'b0, 16'h0000, 6'b000001));
      vecs.push_back(mk(MODE_LOGIC, L_NOT_B,   IV_A,  8'h01, 8'h01, 1'b0, 16'h0000, 6'b000001));
      vecs.push_back(mk(MODE_ARITH, A_ADD,     IV_AB, 8'h12, 8'h34, 1'b0, 16'h0046, 6'b000000));

      @(negedge CLK);
      CE = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge CLK);
         set_in(vecs[i].mode, vecs[i].cmd, vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].cin);
         edge_wait();
         check($sformatf("vec%0d", i), vecs[i].res, vecs[i].flg);
      end

      // Multiplies: (A+1)*(B+1) and (A<<1 truncated)*B
      mul_seq("mul_inc_3_4",  A_MUL_INC, 8'h03, 8'h04, 16'd20);
      mul_seq("mul_shl_81_3", A_MUL_SHL, 8'h81, 8'h03, 16'h0006);
      mul_seq("mul_shl_40_10", A_MUL_SHL, 8'h40, 8'h10, 16'h0800);
      mul_seq("mul_inc_ff_4", A_MUL_INC, 8'hFF, 8'h04, 16'h0500);

      // A different command in the intermediate cycle cancels the multiply
      @(negedge CLK);
      set_in(MODE_ARITH, A_MUL_INC, IV_AB, 8'h03, 8'h04, 1'b0);
      edge_wait();
      check("cancel_mid", last_res, last_flg);
      @(negedge CLK);
      set_in(MODE_ARITH, A_ADD, IV_AB, 8'h01, 8'h02, 1'b0);
      edge_wait();
      check("cancel_add", 16'h0003, 6'b000000);
      edge_wait();
      check("cancel_stays", 16'h0003, 6'b000000);

      // Newest multiply wins over the one in flight
      @(negedge CLK);
      set_in(MODE_ARITH, A_MUL_INC, IV_AB, 8'h03, 8'h04, 1'b0);
      edge_wait();
      check("mul_swap_mid1", 16'h0003, 6'b000000);
      @(negedge CLK);
      set_in(MODE_ARITH, A_MUL_SHL, IV_AB, 8'h05, 8'h07, 1'b0);
      edge_wait();
      check("mul_swap_mid2", 16'h0003, 6'b000000);
      edge_wait();
      check("mul_swap_done", 16'h0046, 6'b000000);

      // CE=0 for 3 cycles in the middle of a multiply
      @(negedge CLK);
      set_in(MODE_ARITH, A_MUL_INC, IV_AB, 8'h09, 8'h09, 1'b0);
      edge_wait();
      check("ce_mul_mid", 16'h0046, 6'b000000);
      @(negedge CLK);
      CE = 1'b0;
      set_in(MODE_LOGIC, L_OR, IV_AB, 8'hAA, 8'h55, 1'b0);
      for (int i = 0; i < 3; i++) begin
         edge_wait();
         check($sformatf("ce_frozen%0d", i), 16'h0046, 6'b000000);
      end
      @(negedge CLK);
      CE = 1'b1;
      set_in(MODE_ARITH, A_MUL_INC, IV_AB, 8'h09, 8'h09, 1'b0);
      edge_wait();
      check("ce_mul_done", 16'h0064, 6'b000000);

      // Reset in the middle of a multiply
      @(negedge CLK);
      set_in(MODE_ARITH, A_MUL_INC, IV_AB, 8'h02, 8'h02, 1'b0);
      edge_wait();
      check("rst_mul_mid", 16'h0064, 6'b000000);
      @(negedge CLK);
      RST = 1'b1;
      edge_wait();
      check("rst_mul_clear", 16'h0000, 6'b000000);
      @(negedge CLK);
      RST = 1'b0;
      edge_wait();
      check("rst_mul_restart", 16'h0000, 6'b000000);
      edge_wait();
      check("rst_mul_done", 16'h0009, 6'b000000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
